// File: rtl/cpu_mult_cell_pipe_pkg.sv
// Shared sizing helpers for the pipelined multiplier cell: slice width and partial-product width.
// No logic; latency and backpressure are defined by the modules that import it.
package cpu_mult_pkg;

   localparam int DEF_DATA_W = 32;

   function automatic int slice_w(input int data_w);
      return data_w / 2;
   endfunction

   // Each slice operand carries one extra bit so the high slice can be sign- or zero-extended.
   function automatic int pp_w(input int data_w);
      return 2 * slice_w(data_w) + 2;
   endfunction

   typedef logic signed [pp_w(DEF_DATA_W)-1:0] pp_t;

endpackage

// File: rtl/cpu_mult_cell_pipe_if.sv
// E-stage operand bus into the multiplier cell and the M-stage result bus back out; no handshake, M_en advances both.
// Macro CPU_MULT_CELL_ACC_EN adds the E_acc / E_acc_clr accumulate controls.
interface cpu_mult_cell_pipe_if #(parameter int DATA_W = 32);

   logic [DATA_W-1:0] E_src1;
   logic [DATA_W-1:0] E_src2;
   logic              E_valid;
   logic              E_sign_a;
   logic              E_sign_b;
   logic              M_en;
`ifdef CPU_MULT_CELL_ACC_EN
   logic              E_acc;
   logic              E_acc_clr;
`endif
   logic [DATA_W-1:0] M_mul_lo;
   logic [DATA_W-1:0] M_mul_hi;
   logic              M_mul_valid;

   modport master (
`ifdef CPU_MULT_CELL_ACC_EN
      output E_acc, E_acc_clr,
`endif
      output E_src1, E_src2, E_valid, E_sign_a, E_sign_b, M_en,
      input  M_mul_lo, M_mul_hi, M_mul_valid
   );

   modport slave (
`ifdef CPU_MULT_CELL_ACC_EN
      input  E_acc, E_acc_clr,
`endif
      input  E_src1, E_src2, E_valid, E_sign_a, E_sign_b, M_en,
      output M_mul_lo, M_mul_hi, M_mul_valid
   );

endinterface

// File: rtl/cpu_mult_cell_pipe_slice_mul.sv
// One registered signed WxW slice multiplier; 1 enabled edge of latency, holds its product while i_en=0.
module cpu_mult_slice_mul #(
   parameter int W         = 17,
   parameter int RESET_VAL = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  i_en,
   input  logic signed [W-1:0]   i_a,
   input  logic signed [W-1:0]   i_b,
   output logic signed [2*W-1:0] o_p
);

   logic signed [2*W-1:0] w_a;
   logic signed [2*W-1:0] w_b;
   logic signed [2*W-1:0] r_p;

   assign w_a = {{W{i_a[W-1]}}, i_a};
   assign w_b = {{W{i_b[W-1]}}, i_b};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_p <= (2*W)'(RESET_VAL);
      end else if (i_en) begin
         r_p <= w_a * w_b;
      end
   end

   assign o_p = r_p;

endmodule

// File: rtl/cpu_mult_cell_pipe.sv
// Two-stage DATA_W x DATA_W multiplier (per-operand signedness), full 2*DATA_W product; 2 enabled edges of latency, M_en=0 freezes all state.
// Macro CPU_MULT_CELL_ACC_EN enables accumulate/clear of the previous {hi,lo} at stage 2.
module cpu_mult_cell_pipe
   import cpu_mult_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int RESET_VAL = 0
) (
   input logic                 clk,
   input logic                 reset_n,
   cpu_mult_cell_pipe_if.slave bus
);

   localparam int SLICE_W = slice_w(DATA_W);
   localparam int OP_W    = SLICE_W + 1;
   localparam int PP_W    = pp_w(DATA_W);
   localparam int PROD_W  = 2 * DATA_W;

   logic signed [OP_W-1:0] w_al, w_ah, w_bl, w_bh;
   logic signed [PP_W-1:0] w_pll, w_plh, w_phl, w_phh;
   logic [PROD_W-1:0]      w_ell, w_elh, w_ehl, w_ehh;
   logic [PROD_W-1:0]      w_prod;
   logic [PROD_W-1:0]      w_next;
   logic [DATA_W-1:0]      r_lo, r_hi;
   logic                   r_v1, r_vld;

   // Low slices are always unsigned; only the top slice sees the sign mode.
   assign w_al = {1'b0, bus.E_src1[SLICE_W-1:0]};
   assign w_ah = {bus.E_sign_a & bus.E_src1[DATA_W-1], bus.E_src1[DATA_W-1:SLICE_W]};
   assign w_bl = {1'b0, bus.E_src2[SLICE_W-1:0]};
   assign w_bh = {bus.E_sign_b & bus.E_src2[DATA_W-1], bus.E_src2[DATA_W-1:SLICE_W]};

   cpu_mult_slice_mul #(.W(OP_W), .RESET_VAL(RESET_VAL)) u_ll (
      .clk(clk), .reset_n(reset_n), .i_en(bus.M_en), .i_a(w_al), .i_b(w_bl), .o_p(w_pll));
   cpu_mult_slice_mul #(.W(OP_W), .RESET_VAL(RESET_VAL)) u_lh (
      .clk(clk), .reset_n(reset_n), .i_en(bus.M_en), .i_a(w_al), .i_b(w_bh), .o_p(w_plh));
   cpu_mult_slice_mul #(.W(OP_W), .RESET_VAL(RESET_VAL)) u_hl (
      .clk(clk), .reset_n(reset_n), .i_en(bus.M_en), .i_a(w_ah), .i_b(w_bl), .o_p(w_phl));
   cpu_mult_slice_mul #(.W(OP_W), .RESET_VAL(RESET_VAL)) u_hh (
      .clk(clk), .reset_n(reset_n), .i_en(bus.M_en), .i_a(w_ah), .i_b(w_bh), .o_p(w_phh));

   assign w_ell = {{(PROD_W-PP_W){w_pll[PP_W-1]}}, w_pll};
   assign w_elh = {{(PROD_W-PP_W){w_plh[PP_W-1]}}, w_plh};
   assign w_ehl = {{(PROD_W-PP_W){w_phl[PP_W-1]}}, w_phl};
   assign w_ehh = {{(PROD_W-PP_W){w_phh[PP_W-1]}}, w_phh};

   // Two's-complement sum modulo 2^PROD_W yields the exact product for every sign mode.
   assign w_prod = w_ell + (w_elh << SLICE_W) + (w_ehl << SLICE_W) + (w_ehh << DATA_W);

`ifdef CPU_MULT_CELL_ACC_EN
   logic r_acc1, r_clr1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_acc1 <= 1'b0;
         r_clr1 <= 1'b0;
      end else if (bus.M_en) begin
         r_acc1 <= bus.E_acc;
         r_clr1 <= bus.E_acc_clr;
      end
   end

   assign w_next = (r_acc1 && !r_clr1) ? ({r_hi, r_lo} + w_prod) : w_prod;
`else
   assign w_next = w_prod;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_v1         <= 1'b0;
         r_vld        <= 1'b0;
         {r_hi, r_lo} <= PROD_W'(RESET_VAL);
      end else if (bus.M_en) begin
         r_v1         <= bus.E_valid;
         r_vld        <= r_v1;
         {r_hi, r_lo} <= w_next;
      end
   end

   assign bus.M_mul_lo    = r_lo;
   assign bus.M_mul_hi    = r_hi;
   assign bus.M_mul_valid = r_vld;

endmodule

// File: tb/tb_cpu_mult_cell_pipe.sv
// Bench for cpu_mult_cell_pipe (DATA_W=32): vector table plus stall, reset and accumulate sequences,
// results checked through an expected-product queue.
module tb_cpu_mult_cell_pipe;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic        sa;
      logic        sb;
      logic [63:0] exp;
   } vec_t;

   localparam int NVEC = 16;
   localparam logic [31:0] IDLE_A = 32'h0000_1234;
   localparam logic [31:0] IDLE_B = 32'h0000_0010;

   logic clk = 1'b0;
   logic reset_n;
   int   n_cmp = 0;
   int   n_err = 0;
   int   n_pop = 0;
   logic [63:0] q[$];
   vec_t tbl[NVEC];

   cpu_mult_cell_pipe_if #(.DATA_W(32)) bus ();

   cpu_mult_cell_pipe #(.DATA_W(32), .RESET_VAL(0)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus));

   always #5 clk = ~clk;

   function automatic logic [63:0] mdl(input logic [31:0] a, input logic [31:0] b,
                                       input logic sa, input logic sb);
      logic signed [63:0] ea, eb;
      ea = sa ? {{32{a[31]}}, a} : {32'b0, a};
      eb = sb ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic sa,
                        input logic sb, input logic v);
      @(negedge clk);
      bus.E_src1   = a;
      bus.E_src2   = b;
      bus.E_sign_a = sa;
      bus.E_sign_b = sb;
      bus.E_valid  = v;
      if (v) q.push_back(mdl(a, b, sa, sb));
   endtask

   // Result monitor: pops one expected product per enabled edge that presents valid.
   initial begin
      logic        en_seen;
      logic [63:0] e;
      forever begin
         @(posedge clk);
         en_seen = bus.M_en && reset_n;
         #1;
         if (en_seen && reset_n && bus.M_mul_valid) begin
            n_pop++;
            if (q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL unexpected_valid: got valid=1 hi=%h lo=%h, required no result",
                        bus.M_mul_hi, bus.M_mul_lo);
            end else begin
               e = q.pop_front();
               chk("product", {bus.M_mul_hi, bus.M_mul_lo}, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int pop0;
      tbl[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 64'hFFFF_FFFE_0000_0001};
      tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 64'h0000_0000_0000_0001};
      tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
      tbl[3] = '{32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 64'h0000_0001_0000_0000};
      tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 64'h4000_0000_0000_0000};
      tbl[5] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 64'hFFFF_FFFF_8000_0000};
      tbl[6] = '{32'h0000_0000, 32'h1234_5678, 1'b1, 1'b1, 64'h0000_0000_0000_0000};
      tbl[7] = '{32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 64'hC000_0000_8000_0000};
      for (int i = 8; i < NVEC; i++) begin
         tbl[i].a  = $urandom;
         tbl[i].b  = $urandom;
         tbl[i].sa = 1'($urandom_range(0, 1));
         tbl[i].sb = 1'($urandom_range(0, 1));
         tbl[i].exp = mdl(tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb);
      end

      reset_n      = 1'b0;
      bus.M_en     = 1'b0;
      bus.E_src1   = '0;
      bus.E_src2   = '0;
      bus.E_valid  = 1'b0;
      bus.E_sign_a = 1'b0;
      bus.E_sign_b = 1'b0;
`ifdef CPU_MULT_CELL_ACC_EN
      bus.E_acc     = 1'b0;
      bus.E_acc_clr = 1'b0;
`endif
      #12;
      chk("reset_lo", {32'b0, bus.M_mul_lo}, 64'h0);
      chk("reset_hi", {32'b0, bus.M_mul_hi}, 64'h0);
      chk("reset_valid", {63'b0, bus.M_mul_valid}, 64'h0);
      @(negedge clk);
      reset_n  = 1'b1;
      bus.M_en = 1'b1;

      // Table vectors, back to back; the queue pairs each with its own output.
      for (int i = 0; i < NVEC; i++) begin
         drive(tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb, 1'b1);
         if (tbl[i].exp !== mdl(tbl[i].a, tbl[i].b, tbl[i].sa, tbl[i].sb))
            $display("table entry %0d disagrees with model", i);
         q[q.size()-1] = tbl[i].exp;
      end
      repeat (4) drive(IDLE_A, IDLE_B, 1'b0, 1'b0, 1'b0);
      chk("table_drained", 64'(q.size()), 64'h0);

      // Stall: A enters stage 1, then M_en low for 3 cycles with B waiting on the inputs.
      pop0 = n_pop;
      drive(32'd7, 32'd9, 1'b0, 1'b0, 1'b1);
      drive(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 1'b1);
      bus.M_en = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("stall_hold_data", {bus.M_mul_hi, bus.M_mul_lo}, mdl(IDLE_A, IDLE_B, 1'b0, 1'b0));
         chk("stall_hold_valid", {63'b0, bus.M_mul_valid}, 64'h0);
      end
      bus.M_en = 1'b1;
      drive(32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 1'b0);
      repeat (4) drive(IDLE_A, IDLE_B, 1'b0, 1'b0, 1'b0);
      chk("stall_result_count", 64'(n_pop - pop0), 64'd2);
      chk("stall_drained", 64'(q.size()), 64'h0);

      // Reset while an op sits in stage 1: in-flight product is dropped.
      drive(32'd100, 32'd3, 1'b0, 1'b0, 1'b1);
      drive(32'd11, 32'd13, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      bus.E_valid = 1'b0;
      reset_n = 1'b0;
      q.delete();
      #1;
      chk("midreset_lo", {32'b0, bus.M_mul_lo}, 64'h0);
      chk("midreset_hi", {32'b0, bus.M_mul_hi}, 64'h0);
      chk("midreset_valid", {63'b0, bus.M_mul_valid}, 64'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("postreset_valid", {63'b0, bus.M_mul_valid}, 64'h0);
      end

`ifdef CPU_MULT_CELL_ACC_EN
      @(negedge clk);
      bus.E_src1 = 32'd3; bus.E_src2 = 32'd4; bus.E_valid = 1'b1;
      bus.E_acc = 1'b0; bus.E_acc_clr = 1'b1;
      q.push_back(64'd12);
      @(negedge clk);
      bus.E_src1 = 32'd5; bus.E_src2 = 32'd6;
      bus.E_acc = 1'b1; bus.E_acc_clr = 1'b0;
      q.push_back(64'd42);
      @(negedge clk);
      bus.E_src1 = 32'd2; bus.E_src2 = 32'd2;
      q.push_back(64'd46);
      @(negedge clk);
      bus.E_valid = 1'b0; bus.E_acc = 1'b0;
      repeat (4) @(negedge clk);
      chk("acc_drained", 64'(q.size()), 64'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
